// File: rtl/lut_bank_cfg_if.sv
// Configuration load port of the LUT bank.
// The master drives start/valid/data and the slave returns ready.
interface lut_bank_cfg_if #(
   parameter int CONF_W = 8
);
   logic              conf_start;
   logic              conf_valid;
   logic [CONF_W-1:0] conf_data;
   logic              conf_ready;

   modport master (output conf_start, output conf_valid, output conf_data, input conf_ready);
   modport slave  (input conf_start, input conf_valid, input conf_data, output conf_ready);
endinterface

// File: rtl/lut_bank_cfg.sv
// Bank of independent K-input LUTs with shadow-loaded, atomically committed configuration.
// Each LUT selects a combinational or a registered output through its mode bit.
module lut_bank_cfg #(
   parameter int INPUTS = 2,
   parameter int LUTS   = 4,
   parameter int CONF_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   lut_bank_cfg_if.slave            conf,
   input  logic [LUTS*INPUTS-1:0]   in_i,
   output logic [LUTS-1:0]          out_o,
   output logic                     configured_o
);
   localparam int TBL   = 2 ** INPUTS;
   localparam int SLICE = TBL + 1;
   localparam int TOTAL = LUTS * SLICE;
   localparam int WORDS = (TOTAL + CONF_W - 1) / CONF_W;
   localparam int CNT_W = $clog2(WORDS + 1);

   typedef enum logic [1:0] {UNCONF, LOAD, COMMIT, RUN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TOTAL-1:0]  shadow_q, shadow_d;
   logic [TOTAL-1:0]  active_q, active_d;
   logic              configured_q, configured_d;
   logic [LUTS-1:0]   flop_q, flop_d;
   logic              accept;

   assign accept = (state_q == LOAD) && conf.conf_valid && !conf.conf_start;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= UNCONF;
         cnt_q        <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         configured_q <= 1'b0;
         flop_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         configured_q <= configured_d;
         flop_q       <= flop_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      active_d     = active_q;
      configured_d = configured_q;
      case (state_q)
         UNCONF, RUN: begin
            if (conf.conf_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (conf.conf_start) begin
               cnt_d = '0;
            end else if (conf.conf_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WORDS - 1)) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            active_d     = shadow_q;
            configured_d = 1'b1;
            state_d      = RUN;
         end
         default: state_d = UNCONF;
      endcase
   end

   always_comb begin
      conf.conf_ready = (state_q == LOAD) && !conf.conf_start;
   end

   assign configured_o = configured_q;

   // Bit gi of the configuration lives in word gi/CONF_W; bits past TOTAL simply have no home.
   for (genvar gi = 0; gi < TOTAL; gi++) begin : g_shadow
      localparam int WI = gi / CONF_W;
      localparam int BI = gi % CONF_W;
      assign shadow_d[gi] = (accept && cnt_q == CNT_W'(WI)) ? conf.conf_data[BI] : shadow_q[gi];
   end

   for (genvar gi = 0; gi < LUTS; gi++) begin : g_lut
      logic [TBL-1:0] tbl;
      logic           mode;
      logic           lut_val;
      assign tbl     = active_q[gi*SLICE +: TBL];
      assign mode    = active_q[gi*SLICE + TBL];
      assign lut_val = tbl[in_i[gi*INPUTS +: INPUTS]];
      // Flop tracks the running table every edge so a mode switch shows one stale cycle.
      assign flop_d[gi] = configured_q & lut_val;
      assign out_o[gi]  = configured_q & (mode ? flop_q[gi] : lut_val);
   end
endmodule
